// File: rtl/router_in_arb.sv
// Three-source input arbiter in front of the router FSM: grants one source per packet (header, payload, parity).
// Define ARB_FIXED_PRIO_EN for fixed priority 0>1>2; otherwise round-robin on packet completion.
module router_in_arb #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [2:0]      src_pkt_valid,
    input  logic [3*DW-1:0] src_data,
    output logic [2:0]      src_stall,
    input  logic            busy,
    output logic            rtr_pkt_valid,
    output logic [DW-1:0]   rtr_data,
    output logic [2:0]      gnt,
    output logic            arb_active
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] HDR     = 2'd1;
    localparam logic [1:0] PAYLOAD = 2'd2;
    localparam logic [1:0] GAP     = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [2:0] gnt_nxt;
    logic [2:0] winner;
    logic [1:0] owner;
    logic       owner_valid;
    logic       pkt_done;
    logic       xfer_phase;

    function automatic logic [DW-1:0] pick_byte(input logic [3*DW-1:0] d, input logic [1:0] idx);
        case (idx)
            2'd1:    return d[DW +: DW];
            2'd2:    return d[2*DW +: DW];
            default: return d[0 +: DW];
        endcase
    endfunction

    always_comb begin
        case (gnt)
            3'b010:  owner = 2'd1;
            3'b100:  owner = 2'd2;
            default: owner = 2'd0;
        endcase
    end

    assign owner_valid = src_pkt_valid[owner];
    assign xfer_phase  = (state == HDR) || (state == PAYLOAD);
    // The parity byte is the one taken while the owner has already dropped valid.
    assign pkt_done    = (state == PAYLOAD) && !busy && !owner_valid;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        winner = 3'b000;
        if (src_pkt_valid[0])      winner = 3'b001;
        else if (src_pkt_valid[1]) winner = 3'b010;
        else if (src_pkt_valid[2]) winner = 3'b100;
    end
`else
    logic [1:0] last_owner;

    // Search starts one past the source that last completed a packet.
    always_comb begin
        logic [1:0] cand;
        winner = 3'b000;
        cand   = (last_owner == 2'd2) ? 2'd0 : last_owner + 2'd1;
        for (int k = 0; k < 3; k++) begin
            if (winner == 3'b000 && src_pkt_valid[cand]) winner[cand] = 1'b1;
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn)       last_owner <= 2'd2;
        else if (pkt_done) last_owner <= owner;
    end
`endif

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        case (state)
            IDLE: begin
                if (|src_pkt_valid && !busy) begin
                    gnt_nxt   = winner;
                    state_nxt = HDR;
                end
            end
            HDR: begin
                // Owner withdrew before its header went through: abandon without touching priority.
                if (!owner_valid) begin
                    gnt_nxt   = 3'b000;
                    state_nxt = IDLE;
                end else if (!busy) begin
                    state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (pkt_done) begin
                    gnt_nxt   = 3'b000;
                    state_nxt = GAP;
                end
            end
            default: begin
                gnt_nxt   = 3'b000;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            gnt   <= 3'b000;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
        end
    end

    always_comb begin
        rtr_pkt_valid = 1'b0;
        rtr_data      = '0;
        src_stall     = src_pkt_valid;
        if (xfer_phase) begin
            rtr_pkt_valid    = owner_valid;
            rtr_data         = pick_byte(src_data, owner);
            src_stall[owner] = busy;
        end
    end

    assign arb_active = (state != IDLE);

endmodule

// File: tb/tb_router_in_arb.sv
// Scoreboard bench for router_in_arb: sources push expected (grant, byte) pairs, a monitor pops them
// on every byte the router accepts and checks the per-cycle grant/stall invariants.
module tb_router_in_arb;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [2:0]      src_pkt_valid = 3'b000;
    logic [3*DW-1:0] src_data = '0;
    logic [2:0]      src_stall;
    logic            busy = 1'b0;
    logic            rtr_pkt_valid;
    logic [DW-1:0]   rtr_data;
    logic [2:0]      gnt;
    logic            arb_active;

    router_in_arb #(.DW(DW)) dut (
        .clk(clk), .resetn(resetn), .src_pkt_valid(src_pkt_valid), .src_data(src_data),
        .src_stall(src_stall), .busy(busy), .rtr_pkt_valid(rtr_pkt_valid), .rtr_data(rtr_data),
        .gnt(gnt), .arb_active(arb_active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] g;
        logic [7:0] d;
    } exp_t;

    exp_t       sbq[$];
    logic [8:0] srcq[3][$];   // bit 8 marks the parity byte (presented with valid low)
    bit         manual = 1'b0;
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_byte(input int s, input logic [7:0] b, input bit par);
        srcq[s].push_back({par, b});
        sbq.push_back({3'(1 << s), b});
    endtask

    task automatic send_pkt(input int s, input logic [7:0] hdr, input int n, input logic [7:0] base);
        logic [7:0] par;
        logic [7:0] b;
        par = hdr;
        add_byte(s, hdr, 1'b0);
        for (int k = 0; k < n; k++) begin
            b = 8'(base * (k + 1));
            par ^= b;
            add_byte(s, b, 1'b0);
        end
        add_byte(s, par, 1'b1);
    endtask

    function automatic bit src_empty();
        return srcq[0].size() == 0 && srcq[1].size() == 0 && srcq[2].size() == 0;
    endfunction

    task automatic drive();
        if (!manual) begin
            for (int i = 0; i < 3; i++) begin
                if (srcq[i].size() > 0) begin
                    src_pkt_valid[i]       = !srcq[i][0][8];
                    src_data[i*DW +: DW] = srcq[i][0][7:0];
                end else begin
                    src_pkt_valid[i]       = 1'b0;
                    src_data[i*DW +: DW] = '0;
                end
            end
        end
    endtask

    // One clock: a source advances only when it was not stalled at the edge.
    task automatic step();
        logic [2:0] st;
        @(negedge clk);
        st = src_stall;
        @(posedge clk);
        #1;
        if (!manual && resetn) begin
            for (int i = 0; i < 3; i++)
                if (srcq[i].size() > 0 && !st[i]) void'(srcq[i].pop_front());
        end
        drive();
    endtask

    task automatic drain(input string name, input int maxc);
        int n;
        n = 0;
        while ((sbq.size() > 0 || !src_empty()) && n < maxc) begin
            step();
            n++;
        end
        checks++;
        if (sbq.size() > 0 || !src_empty()) begin
            errors++;
            $display("FAIL %s_timeout: %0d bytes still expected after %0d cycles", name, sbq.size(), maxc);
        end
    endtask

    task automatic flush();
        sbq.delete();
        for (int i = 0; i < 3; i++) srcq[i].delete();
    endtask

    // Monitor: invariants every cycle, plus scoreboard pop on each accepted byte.
    initial begin
        bit hdr_seen;
        int o;
        exp_t e;
        hdr_seen = 1'b0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            o = gnt[1] ? 1 : (gnt[2] ? 2 : 0);
            check("gnt_onehot", 32'($countones(gnt) <= 1), 1);
            for (int j = 0; j < 3; j++)
                if (!gnt[j] && src_pkt_valid[j]) check("nonowner_stall", src_stall[j], 1);
            if (gnt == 3'b000) begin
                check("nogrant_out", {rtr_pkt_valid, rtr_data}, 0);
                check("nogrant_stall", src_stall, src_pkt_valid);
            end else begin
                check("owner_stall", src_stall[o], busy);
            end
            if (resetn && gnt != 3'b000 && !busy && (rtr_pkt_valid || hdr_seen)) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h from gnt %b, none expected", rtr_data, gnt);
                end else begin
                    e = sbq.pop_front();
                    check("xfer_gnt", gnt, e.g);
                    check("xfer_data", rtr_data, e.d);
                end
                hdr_seen = rtr_pkt_valid;
            end
            if (!resetn || gnt == 3'b000) hdr_seen = 1'b0;
        end
    end

    initial begin
        logic [7:0] d0;

        // Reset
        step();
        step();
        resetn = 1'b1;
        #1;
        check("rst_gnt", gnt, 3'b000);
        check("rst_active", arb_active, 0);
        check("rst_rvalid", rtr_pkt_valid, 0);
        check("rst_rdata", rtr_data, 0);
        check("rst_stall", src_stall, 3'b000);

        // Single packet from source 1
        add_byte(1, 8'h01, 1'b0);
        add_byte(1, 8'h11, 1'b0);
        add_byte(1, 8'h22, 1'b0);
        add_byte(1, 8'h32, 1'b1);
        drive();
        step();
        #1;
        check("t1_gnt_cycle2", gnt, 3'b010);
        check("t1_active", arb_active, 1);
        drain("t1", 50);
        #1;
        check("t1_gap_active", arb_active, 1);
        check("t1_gap_gnt", gnt, 3'b000);
        step();
        #1;
        check("t1_idle_active", arb_active, 0);

        // All three sources request together straight after reset
        resetn = 1'b0;
        step();
        resetn = 1'b1;
`ifdef ARB_FIXED_PRIO_EN
        send_pkt(0, 8'hA0, 2, 8'h01);
        send_pkt(0, 8'hA4, 1, 8'h07);
        send_pkt(1, 8'hB0, 2, 8'h02);
        send_pkt(2, 8'hC0, 3, 8'h03);
`else
        send_pkt(0, 8'hA0, 2, 8'h01);
        send_pkt(1, 8'hB0, 2, 8'h02);
        send_pkt(2, 8'hC0, 3, 8'h03);
        send_pkt(0, 8'hA4, 1, 8'h07);
`endif
        drive();
        step();
        #1;
        check("t2_first_gnt", gnt, 3'b001);
        drain("t2", 200);
        step();
        step();

        // busy held for three cycles in the middle of source 2's payload
        send_pkt(2, 8'h40, 5, 8'h03);
        drive();
        step();
        step();
        step();
        busy = 1'b1;
        #1;
        d0 = rtr_data;
        for (int k = 0; k < 3; k++) begin
            check("t3_busy_stall", src_stall[2], 1);
            check("t3_busy_hold", rtr_data, d0);
            step();
            #1;
        end
        busy = 1'b0;
        drain("t3", 50);
        step();
        step();

        // Source 0 withdraws in HDR, then 0 and 1 compete: 0 must still win
        manual = 1'b1;
        src_pkt_valid[0] = 1'b1;
        src_data[0 +: DW] = 8'h55;
        step();
        #1;
        check("t4_hdr_gnt", gnt, 3'b001);
        src_pkt_valid[0] = 1'b0;
        step();
        #1;
        check("t4_abort_gnt", gnt, 3'b000);
        check("t4_abort_active", arb_active, 0);
        manual = 1'b0;
        send_pkt(0, 8'h60, 1, 8'h09);
        send_pkt(1, 8'h61, 2, 8'h0A);
        drive();
        step();
        #1;
        check("t4_keep_prio", gnt, 3'b001);
        drain("t4", 100);
        step();
        step();

        // Reset in the middle of source 2's payload
        send_pkt(2, 8'h70, 4, 8'h05);
        drive();
        step();
        step();
        step();
        #1;
        check("t5_in_payload", gnt, 3'b100);
        resetn = 1'b0;
        step();
        #1;
        check("t5_rst_gnt", gnt, 3'b000);
        check("t5_rst_rvalid", rtr_pkt_valid, 0);
        check("t5_rst_active", arb_active, 0);
        flush();
        resetn = 1'b1;
        send_pkt(0, 8'h80, 1, 8'h0B);
        send_pkt(2, 8'h82, 1, 8'h0C);
        drive();
        step();
        #1;
        check("t5_after_rst_gnt", gnt, 3'b001);
        drain("t5", 100);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/router_in_arb.md
ROUTER_IN_ARB -- requirements
Module: router_in_arb

Interface
REQ-001 Parameter: DW, 8, byte width of router input data.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: resetn  input  1  reset, synchronous, active-low.
REQ-004 Port: src_pkt_valid  input  3  per-source packet_valid, bit i = source i.
REQ-005 Port: src_data  input  3*DW  per-source data, source i at bits [i*DW +: DW].
REQ-006 Port: src_stall  output  3  per-source hold; the source SHALL keep its data/valid unchanged while its bit is 1.
REQ-007 Port: busy  input  1  router FSM busy; no header or data transfer while high.
REQ-008 Port: rtr_pkt_valid  output  1  packet_valid to the router.
REQ-009 Port: rtr_data  output  DW  data to the router.
REQ-010 Port: gnt  output  3  one-hot registered grant, 0 when no owner.
REQ-011 Port: arb_active  output  1  high in every state except IDLE.

Function
REQ-012 FSM states SHALL be IDLE, HDR, PAYLOAD and GAP; state and gnt are registered; all other outputs are combinational from state, gnt and inputs.
REQ-013 IDLE: gnt=0, rtr_pkt_valid=0, rtr_data=0, src_stall=src_pkt_valid; if any src_pkt_valid bit=1 and busy=0, load gnt with the arbitration winner and go to HDR, else stay.
REQ-014 Arbitration SHALL be round-robin: search starts at (last_owner+1) mod 3; last_owner updates only on packet completion (PAYLOAD->GAP).
REQ-015 In HDR/PAYLOAD with owner g: rtr_pkt_valid=src_pkt_valid[g], rtr_data=src_data[g], src_stall[g]=busy, src_stall[j!=g]=src_pkt_valid[j].
REQ-016 HDR: header transfers on the cycle with busy=0 and src_pkt_valid[g]=1, then go to PAYLOAD; busy=1 holds HDR.
REQ-017 HDR with src_pkt_valid[g]=0 (protocol violation) SHALL return to IDLE, clear gnt, leave last_owner unchanged.
REQ-018 PAYLOAD: each cycle with busy=0 transfers one byte; the byte on the cycle where src_pkt_valid[g]=0 and busy=0 is the parity byte, after which go to GAP.
REQ-019 PAYLOAD with busy=1 holds state and keeps src_stall[g]=1, regardless of src_pkt_valid[g].
REQ-020 GAP: exactly one cycle, gnt=0, rtr_pkt_valid=0, rtr_data=0, src_stall=src_pkt_valid; then go to IDLE.
REQ-021 Since IDLE requires busy=0, back-to-back packets SHALL be separated by at least GAP plus the router's busy parity cycles.
REQ-022 At most one gnt bit SHALL be 1 in any cycle; src_stall of a non-owner SHALL never be 0 while that source's src_pkt_valid=1.

Reset
REQ-023 While resetn=0 at a clk edge: state=IDLE, gnt=0, last_owner=2 so that source 0 wins first.
REQ-024 Reset mid-packet SHALL abandon the packet; no output depends on pre-reset state after the edge.

Configuration
REQ-025 Macro ARB_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority 0>1>2 and last_owner SHALL not exist; when undefined, the round-robin of REQ-014 applies.

Verification
REQ-026 Single source 1, busy=0: header 0x01, payload 0x11,0x22, parity 0x32 -> gnt=3'b010 from cycle 2, four bytes on rtr_data in order, GAP, IDLE.
REQ-027 All three request at once after reset -> grant order 0,1,2,0 (macro undefined); 0,0,0 while source 0 keeps requesting (macro defined).
REQ-028 busy=1 for 3 cycles mid-payload -> src_stall[g]=1 for those 3 cycles, rtr_data held constant, no byte lost or duplicated.
REQ-029 Owner drops src_pkt_valid in HDR -> IDLE next cycle, gnt=0, the same source keeps priority.
REQ-030 resetn=0 in PAYLOAD of source 2 -> next cycle gnt=0, rtr_pkt_valid=0, a subsequent request from sources 0 and 2 grants source 0.
REQ-031 Every test: assert one-hot-or-zero gnt and REQ-022 each cycle.
